// File: rtl/matrix_display_reader_if.sv
// rtl/matrix_display_reader_if.sv - storage read bus and tx byte stream of the matrix display reader
interface matrix_display_reader_if;
  logic       stor_start_disp;
  logic [3:0] stor_matrix_id;
  logic       stor_read_en;
  logic [7:0] stor_data;
  logic       stor_meta_valid;
  logic [2:0] stor_meta_m;
  logic [2:0] stor_meta_n;
  logic       stor_error;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output stor_start_disp, stor_matrix_id, stor_read_en, tx_data, tx_valid,
    input  stor_data, stor_meta_valid, stor_meta_m, stor_meta_n, stor_error, tx_ready
  );

  modport slave (
    input  stor_start_disp, stor_matrix_id, stor_read_en, tx_data, tx_valid,
    output stor_data, stor_meta_valid, stor_meta_m, stor_meta_n, stor_error, tx_ready
  );
endinterface

// File: rtl/matrix_display_reader.sv
// rtl/matrix_display_reader.sv - fetches one stored matrix and streams it as decimal ASCII text rows
module matrix_display_reader #(
  parameter int         RD_LAT       = 2,
  parameter int         META_TIMEOUT = 15,
  parameter logic [7:0] SEP_CHAR     = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] matrix_id,
  output logic       busy,
  output logic       done,
  output logic       err,
  matrix_display_reader_if.master bus
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_META = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_CONV      = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_FETCH     = 3'd5;

  logic [2:0] state_q, state_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       start_disp_q, start_disp_d, read_en_q, read_en_d;
  logic [3:0] id_q, id_d;
  logic [2:0] m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
  logic [3:0] lat_q, lat_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] elem_q, elem_d;
  logic [3:0] h_q, h_d, t_q, t_d, u_q, u_d;
  logic [1:0] ndig_q, ndig_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       last_col, last_row, meta_bad;
  logic [2:0] nbytes;

  // Byte k of an element: significant digits first, then separator or CR LF.
  function automatic logic [7:0] byte_at(input logic [2:0] k, input logic [1:0] nd,
                                         input logic [3:0] h, input logic [3:0] t,
                                         input logic [3:0] u, input logic last);
    logic [2:0] p;
    logic [3:0] d;
    logic [7:0] b;
    p = k + 3'd3 - {1'b0, nd};
    case (p)
      3'd0:    d = h;
      3'd1:    d = t;
      default: d = u;
    endcase
    if (k < {1'b0, nd}) b = 8'h30 + {4'h0, d};
    else if (last)      b = (k == {1'b0, nd}) ? 8'h0D : 8'h0A;
    else                b = SEP_CHAR;
    return b;
  endfunction

  assign last_col = (col_q == n_q - 3'd1);
  assign last_row = (row_q == m_q - 3'd1);
  assign nbytes   = {1'b0, ndig_q} + (last_col ? 3'd2 : 3'd1);
  assign meta_bad = (bus.stor_meta_m == 3'd0) || (bus.stor_meta_m > 3'd5) ||
                    (bus.stor_meta_n == 3'd0) || (bus.stor_meta_n > 3'd5);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    start_disp_d = 1'b0;
    read_en_d    = 1'b0;
    id_d         = id_q;
    m_d          = m_q;
    n_d          = n_q;
    row_d        = row_q;
    col_d        = col_q;
    lat_d        = lat_q;
    tmo_d        = tmo_q;
    elem_d       = elem_q;
    h_d          = h_q;
    t_d          = t_q;
    u_d          = u_q;
    ndig_d       = ndig_q;
    bidx_d       = bidx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          id_d         = matrix_id;
          busy_d       = 1'b1;
          start_disp_d = 1'b1;
          tmo_d        = 8'd0;
          state_d      = S_WAIT_META;
        end
      end
      S_WAIT_META: begin
        if (bus.stor_error || (bus.stor_meta_valid && meta_bad)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (bus.stor_meta_valid) begin
          m_d     = bus.stor_meta_m;
          n_d     = bus.stor_meta_n;
          row_d   = 3'd0;
          col_d   = 3'd0;
          lat_d   = 4'd1;
          state_d = S_WAIT_DATA;
        end else if (tmo_q == 8'(META_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WAIT_DATA: begin
        if (lat_q <= 4'd1) begin
          elem_d  = bus.stor_data;
          state_d = S_CONV;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_CONV: begin
        h_d     = 4'(elem_q / 8'd100);
        t_d     = 4'((elem_q / 8'd10) % 8'd10);
        u_d     = 4'(elem_q % 8'd10);
        ndig_d  = (elem_q >= 8'd100) ? 2'd3 : (elem_q >= 8'd10) ? 2'd2 : 2'd1;
        bidx_d  = 3'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_valid_q) begin
          tx_data_d  = byte_at(bidx_q, ndig_q, h_q, t_q, u_q, last_col);
          tx_valid_d = 1'b1;
        end else if (bus.tx_ready) begin
          if (bidx_q == nbytes - 3'd1) begin
            tx_valid_d = 1'b0;
            read_en_d  = 1'b1;
            state_d    = S_FETCH;
          end else begin
            bidx_d    = bidx_q + 3'd1;
            tx_data_d = byte_at(bidx_q + 3'd1, ndig_q, h_q, t_q, u_q, last_col);
          end
        end
      end
      S_FETCH: begin
        if (last_col && last_row) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          col_d   = last_col ? 3'd0 : col_q + 3'd1;
          row_d   = last_col ? row_q + 3'd1 : row_q;
          lat_d   = 4'(RD_LAT);
          state_d = S_WAIT_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_disp_q <= 1'b0;
      read_en_q    <= 1'b0;
      id_q         <= 4'd0;
      m_q          <= 3'd0;
      n_q          <= 3'd0;
      row_q        <= 3'd0;
      col_q        <= 3'd0;
      lat_q        <= 4'd0;
      tmo_q        <= 8'd0;
      elem_q       <= 8'd0;
      h_q          <= 4'd0;
      t_q          <= 4'd0;
      u_q          <= 4'd0;
      ndig_q       <= 2'd0;
      bidx_q       <= 3'd0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_disp_q <= start_disp_d;
      read_en_q    <= read_en_d;
      id_q         <= id_d;
      m_q          <= m_d;
      n_q          <= n_d;
      row_q        <= row_d;
      col_q        <= col_d;
      lat_q        <= lat_d;
      tmo_q        <= tmo_d;
      elem_q       <= elem_d;
      h_q          <= h_d;
      t_q          <= t_d;
      u_q          <= u_d;
      ndig_q       <= ndig_d;
      bidx_q       <= bidx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign bus.stor_start_disp = start_disp_q;
  assign bus.stor_matrix_id  = id_q;
  assign bus.stor_read_en    = read_en_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_valid        = tx_valid_q;
endmodule

// File: tb/tb_matrix_display_reader.sv
// tb/tb_matrix_display_reader.sv - scoreboard bench for matrix_display_reader with a storage responder
module tb_matrix_display_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] matrix_id = 4'd0;
  logic       busy, done, err;

  matrix_display_reader_if bus_if();

  matrix_display_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_id(matrix_id),
    .busy(busy), .done(done), .err(err), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem[25];
  int         mode = 0;   // 0 meta reply, 1 error reply, 2 silent
  logic [2:0] cfg_m = 3'd1, cfg_n = 3'd1;
  bit         stall = 1'b0;
  int         cyc = 0, sd_cyc = 0, err_delay = 0;
  int         tx_cnt = 0, rd_cnt = 0, sd_cnt = 0, done_cnt = 0, err_cnt = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_row(string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_start(logic [3:0] id);
    @(negedge clk);
    start = 1'b1;
    matrix_id = id;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(int base, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt + err_cnt > base) break;
    end
    chk("episode_ends", int'(done_cnt + err_cnt > base), 1);
    repeat (3) @(negedge clk);
  endtask

  // Storage responder: meta one cycle after the request, next element RD_LAT cycles after a read strobe.
  initial begin
    int idx, resp;
    bit pend;
    idx = 0; resp = 0; pend = 1'b0;
    bus_if.stor_data = 8'd0; bus_if.stor_meta_valid = 1'b0; bus_if.stor_error = 1'b0;
    bus_if.stor_meta_m = 3'd0; bus_if.stor_meta_n = 3'd0;
    forever begin
      @(negedge clk);
      bus_if.stor_meta_valid = 1'b0;
      bus_if.stor_error = 1'b0;
      if (!rst_n) begin
        idx = 0; resp = 0; pend = 1'b0;
      end else begin
        if (pend) begin
          idx++;
          if (idx < 25) bus_if.stor_data = mem[idx];
          pend = 1'b0;
        end
        if (bus_if.stor_read_en) pend = 1'b1;
        if (resp > 0) begin
          resp--;
          if (resp == 0) begin
            if (mode == 1) bus_if.stor_error = 1'b1;
            else begin
              bus_if.stor_meta_valid = 1'b1;
              bus_if.stor_meta_m = cfg_m;
              bus_if.stor_meta_n = cfg_n;
              idx = 0;
              bus_if.stor_data = mem[0];
            end
          end
        end
        if (bus_if.stor_start_disp) resp = (mode == 2) ? 0 : (mode == 1) ? 2 : 1;
      end
    end
  end

  initial begin
    bus_if.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus_if.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and checks hold-while-stalled.
  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0; pd = 8'd0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) pv = 1'b0;
      else begin
        if (pv) begin
          chk("tx_hold_valid", bus_if.tx_valid, 1);
          chk("tx_hold_data", bus_if.tx_data, pd);
        end
        if (bus_if.tx_valid && bus_if.tx_ready) begin
          tx_cnt++;
          if (exp_q.size() == 0) chk("tx_extra_byte", exp_q.size(), 1);
          else chk("tx_byte", bus_if.tx_data, exp_q.pop_front());
        end
        pv = bus_if.tx_valid && !bus_if.tx_ready;
        pd = bus_if.tx_data;
        if (bus_if.stor_start_disp) begin sd_cnt++; sd_cyc = cyc; end
        if (bus_if.stor_read_en) rd_cnt++;
        if (done) done_cnt++;
        if (err) begin err_cnt++; err_delay = cyc - sd_cyc; end
        if (done || err) chk("done_err_exclusive", int'(done & err), 0);
      end
    end
  end

  initial begin
    int r0, d0, e0, t0, s0;
    for (int i = 0; i < 25; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tx_valid", bus_if.tx_valid, 0);
    chk("rst_start_disp", bus_if.stor_start_disp, 0);
    chk("rst_read_en", bus_if.stor_read_en, 0);
    chk("rst_matrix_id", bus_if.stor_matrix_id, 0);
    rst_n = 1'b1;

    // 2x3 matrix, with a second start while busy
    mode = 0; cfg_m = 3'd2; cfg_n = 3'd3;
    mem[0] = 8'd1; mem[1] = 8'd20; mem[2] = 8'd255; mem[3] = 8'd0; mem[4] = 8'd7; mem[5] = 8'd100;
    push_row("1 20 255"); push_row("0 7 100");
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; t0 = tx_cnt; s0 = sd_cnt;
    pulse_start(4'd5);
    repeat (8) @(negedge clk);
    pulse_start(4'd9);
    chk("id_held_while_busy", bus_if.stor_matrix_id, 5);
    wait_end(d0 + e0, 500);
    chk("m2x3_read_en", rd_cnt - r0, 6);
    chk("m2x3_done", done_cnt - d0, 1);
    chk("m2x3_err", err_cnt - e0, 0);
    chk("m2x3_bytes", tx_cnt - t0, 19);
    chk("m2x3_start_disp", sd_cnt - s0, 1);
    chk("m2x3_busy_after", busy, 0);
    chk("m2x3_queue_empty", exp_q.size(), 0);

    // 1x1 matrix holding 0
    cfg_m = 3'd1; cfg_n = 3'd1; mem[0] = 8'd0;
    push_row("0");
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; t0 = tx_cnt;
    pulse_start(4'd1);
    wait_end(d0 + e0, 200);
    chk("m1x1_read_en", rd_cnt - r0, 1);
    chk("m1x1_done", done_cnt - d0, 1);
    chk("m1x1_bytes", tx_cnt - t0, 3);

    // storage error two cycles after the request
    mode = 1;
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; t0 = tx_cnt;
    pulse_start(4'd2);
    wait_end(d0 + e0, 100);
    chk("serr_err", err_cnt - e0, 1);
    chk("serr_delay", err_delay, 3);
    chk("serr_bytes", tx_cnt - t0, 0);
    chk("serr_read_en", rd_cnt - r0, 0);
    chk("serr_busy_after", busy, 0);

    // silent storage: meta timeout
    mode = 2;
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; t0 = tx_cnt;
    pulse_start(4'd3);
    wait_end(d0 + e0, 100);
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_delay", err_delay, 15);
    chk("tmo_bytes", tx_cnt - t0, 0);

    // out-of-range row count reported in meta
    mode = 0; cfg_m = 3'd6; cfg_n = 3'd2;
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; t0 = tx_cnt;
    pulse_start(4'd4);
    wait_end(d0 + e0, 100);
    chk("badm_err", err_cnt - e0, 1);
    chk("badm_done", done_cnt - d0, 0);
    chk("badm_read_en", rd_cnt - r0, 0);
    chk("badm_bytes", tx_cnt - t0, 0);

    // 5x5 of 0..24 with random tx stalls
    cfg_m = 3'd5; cfg_n = 3'd5;
    for (int i = 0; i < 25; i++) mem[i] = 8'(i);
    push_row("0 1 2 3 4"); push_row("5 6 7 8 9"); push_row("10 11 12 13 14");
    push_row("15 16 17 18 19"); push_row("20 21 22 23 24");
    stall = 1'b1;
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; t0 = tx_cnt;
    pulse_start(4'd7);
    wait_end(d0 + e0, 3000);
    stall = 1'b0;
    chk("m5x5_bytes", tx_cnt - t0, 70);
    chk("m5x5_read_en", rd_cnt - r0, 25);
    chk("m5x5_done", done_cnt - d0, 1);
    chk("m5x5_queue_empty", exp_q.size(), 0);

    // 3x3 interrupted by reset mid-row, then a complete rerun
    cfg_m = 3'd3; cfg_n = 3'd3;
    mem[0] = 8'd3; mem[1] = 8'd45; mem[2] = 8'd200; mem[3] = 8'd9; mem[4] = 8'd0;
    mem[5] = 8'd77; mem[6] = 8'd128; mem[7] = 8'd64; mem[8] = 8'd5;
    push_row("3 45 200"); push_row("9 0 77"); push_row("128 64 5");
    t0 = tx_cnt;
    pulse_start(4'd6);
    for (int i = 0; i < 300 && (tx_cnt - t0) < 4; i++) @(negedge clk);
    chk("rst_point_reached", int'((tx_cnt - t0) >= 4), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_valid", bus_if.tx_valid, 0);
    chk("mid_rst_read_en", bus_if.stor_read_en, 0);
    chk("mid_rst_start_disp", bus_if.stor_start_disp, 0);
    chk("mid_rst_done_err", int'(done | err), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_row("3 45 200"); push_row("9 0 77"); push_row("128 64 5");
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; t0 = tx_cnt;
    pulse_start(4'd6);
    wait_end(d0 + e0, 1000);
    chk("rerun_bytes", tx_cnt - t0, 28);
    chk("rerun_read_en", rd_cnt - r0, 9);
    chk("rerun_done", done_cnt - d0, 1);
    chk("rerun_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix_display_reader.md
Name: matrix_display_reader

Overview:
- Consumer end of the matrix storage display interface.
- On a `start` request it asks storage for one matrix by ID and pulls every element with read strobes.
- Each 8-bit element is converted to unsigned decimal ASCII and streamed over a valid/ready byte interface into the UART transmitter, producing one text row per matrix row.

Parameters:
- RD_LAT, 2, cycles from a `stor_read_en` pulse until `stor_data` holds the next element.
- META_TIMEOUT, 15, cycles to wait for `stor_meta_valid` or `stor_error` after `stor_start_disp` before aborting.
- SEP_CHAR, 8'h20, column separator byte.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request to display the matrix at `matrix_id`; single-cycle pulse
- matrix_id  input  4  matrix slot to display
- busy  output  1  high from accepted start until done/err
- done  output  1  one-cycle pulse after the last byte is accepted
- err  output  1  one-cycle pulse on storage error or timeout
- stor_start_disp  output  1  one-cycle request pulse to storage
- stor_matrix_id  output  4  ID presented with `stor_start_disp`, held while busy
- stor_read_en  output  1  one-cycle advance strobe to storage
- stor_data  input  8  current element from storage
- stor_meta_valid  input  1  storage accepted the request; `stor_meta_m`/`stor_meta_n` valid this cycle
- stor_meta_m  input  3  row count (1..5)
- stor_meta_n  input  3  column count (1..5)
- stor_error  input  1  storage rejected the request
- tx_data  output  8  ASCII byte
- tx_valid  output  1  byte available
- tx_ready  input  1  transmitter can accept

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- IDLE:
  - `start` high: latch `matrix_id` to `stor_matrix_id`, set `busy`, drive `stor_start_disp`=1 for exactly one cycle, go to WAIT_META.
  - `start` while busy is ignored.
- WAIT_META:
  - `stor_error`: pulse `err`, clear `busy`, return to IDLE. No tx bytes are sent.
  - `stor_meta_valid`: latch m, n; row=0, col=0; go to WAIT_DATA with a latency counter of 1.
  - Neither within META_TIMEOUT cycles: pulse `err`, clear `busy`, go to IDLE.
  - Same cycle error+valid: error wins.
- WAIT_DATA:
  - Count down the latency counter, then sample `stor_data` into the element register and go to CONV.
  - First element: 1 cycle after meta. Later elements: RD_LAT cycles after `stor_read_en`.
- CONV:
  - One cycle. Split value v into h=v/100, t=(v/10)%10, u=v%10.
  - Digit count: 3 if v>=100, 2 if v>=10, else 1. No leading zeros; v=0 sends "0".
  - Digit byte = 8'h30+digit.
- SEND: emit the digit bytes, then the suffix byte(s):
  - col<n-1: SEP_CHAR.
  - col==n-1: 8'h0D then 8'h0A.
- tx handshake:
  - A byte transfers on a rising edge with `tx_valid` & `tx_ready`.
  - `tx_data` and `tx_valid` are stable until transfer; `tx_valid` never drops without a transfer.
  - Back-to-back bytes are allowed (one per cycle when `tx_ready` is held high).
- FETCH:
  - After the last byte of an element transfers, pulse `stor_read_en` for one cycle. This is issued for every element including the last, so storage terminates its read.
  - Advance col, wrapping to 0 with row+1.
  - More elements remain: go to WAIT_DATA with counter=RD_LAT.
  - After the final element: pulse `done`, clear `busy`, go to IDLE.
- Counters:
  - col and row are 3-bit and compared against latched n-1 and m-1.
  - Total element count is m*n, at most 25.
- Latched m or n equal to 0 or greater than 5: treated as a storage error. Pulse `err`, no tx, no `stor_read_en`.
- Async reset mid-transfer:
  - Immediately drops `tx_valid`, `busy` and the strobes.
  - The partial line is not completed.
  - The storage side is reset by the same rst_n.
- `done` and `err` never assert in the same cycle; neither asserts outside a busy episode.

Test Plan:
- 2x3 matrix [1,20,255; 0,7,100], `tx_ready`=1 -> bytes "1 20 255\r\n0 7 100\r\n" (19 bytes); exactly 6 `stor_read_en` pulses; one `done`; `busy` low afterwards.
- 1x1 matrix value 0 -> bytes 8'h30, 8'h0D, 8'h0A; one `stor_read_en`; `done`.
- `stor_error` asserted 2 cycles after `stor_start_disp` -> `err` pulse; zero tx bytes; zero `stor_read_en`. Repeat with no response for 15 cycles -> `err` at timeout.
- Random `tx_ready` stalls (~50% duty) on a 5x5 matrix of values 0..24 -> identical byte stream to the no-stall run; `tx_data` stable while `tx_valid` & !`tx_ready`.
- `start` pulsed again while busy with a different ID -> ignored; `stor_matrix_id` unchanged; a single `stor_start_disp`.
- rst_n asserted mid-row of a 3x3 read -> all outputs 0 on the next sampled edge; a fresh `start` after release produces a complete correct dump.
